d_flipflop_en: RTL and testbench
================================

Name: d_flipflop_en

Overview:
- Clocked storage element with load enable. Captures data input A on the rising edge of clock when enable B is high, and holds otherwise.
- Generalised to a WIDTH-bit word and an optional chain of STAGES registers, so the same block serves both as a basic D flip-flop and as a short enabled delay line.
- Sits directly in datapaths as a leaf register. Default parameters give a 1-bit, single-stage flip-flop.

Parameters:
- WIDTH, 1, bit width of A and Q.
- STAGES, 1, number of cascaded register stages, minimum 1.
- RESET_VAL, 0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  data input.
- B  input  1  load enable. 1 = capture/shift, 0 = hold.
- Q  output  WIDTH  registered output, equal to the last stage.

Behaviour:
- All state updates on the rising edge of clock only. No combinational path from A or B to Q.
- Reset:
  - If reset=1 at a rising edge, every stage is loaded with RESET_VAL, and Q=RESET_VAL after that edge.
  - Reset has priority over B.
  - Q before the first reset edge is undefined.
- Enable (when reset=0):
  - B=1: stage[0] <= A, and stage[k] <= stage[k-1] for k=1..STAGES-1.
  - B=0: all stages hold.
- Q = stage[STAGES-1].
- Latency:
  - With STAGES=1, Q reflects A sampled at the most recent edge where B=1.
  - In general, A sampled at an enabled edge appears on Q after STAGES enabled edges. Disabled edges do not advance the chain.
- Simultaneous events:
  - reset=1 with B=1: reset wins and A is discarded.
  - A changing in the same delta as the edge follows standard nonblocking semantics: the pre-edge value is captured.
- Reset mid-operation: all in-flight data in every stage is discarded; the chain restarts from RESET_VAL.
- Width rules: A, Q and RESET_VAL are exactly WIDTH bits. No extension or truncation inside the block.
- STAGES < 1 is illegal and shall be flagged with an elaboration-time error.

Decomposition:
- Shared package holds:
  - DFF_DEFAULT_WIDTH = 1
  - DFF_DEFAULT_STAGES = 1
  - a reset-value constant, all zeros.
- One natural sub-module: d_ff_stage. It is a single WIDTH-bit register with clock, reset, enable, d and q, plus a RESET_VAL parameter.
- The top level instantiates STAGES copies of d_ff_stage in a generate loop and chains q to d.

Test Plan:
- Reset: WIDTH=1, STAGES=1. reset=1 for one edge with A=1, B=1 -> Q=0 after the edge. Release reset.
- Hold: clock period 10. Edges at t=5,15,25,35 with (A,B) = (0,0), (1,0), (0,1), (1,1) -> Q = 0, 0, 0, 1 after the respective edges.
- Enable toggling: A=1, B=1 -> Q=1. Then A=0, B=0 for 3 edges -> Q stays 1. Then B=1 -> Q=0 on the next edge.
- Reset priority: Q=1, then reset=1 with A=1, B=1 -> Q=0. Next edge, reset=0, A=1, B=1 -> Q=1.
- Delay line: WIDTH=8, STAGES=3, RESET_VAL=8'hA5.
  - After reset, Q=8'hA5.
  - Apply A=8'h01, 8'h02, 8'h03 with B=1 on consecutive edges -> Q=8'h01 after the third edge.
  - Insert one edge with B=0 -> Q unchanged.
  - Next enabled edge -> Q=8'h02.
- Mid-operation reset: STAGES=3 with 8'h01, 8'h02 in flight. Assert reset for one edge -> Q=8'hA5. Then 3 enabled edges of A=8'h7F -> Q=8'h7F.

Source files
------------

// File: rtl/d_flipflop_en_pkg.sv
// Shared defaults for the enabled D flip-flop / short enabled delay line.
package d_flipflop_en_pkg;

  localparam int unsigned DFF_DEFAULT_WIDTH  = 1;
  localparam int unsigned DFF_DEFAULT_STAGES = 1;

  // Replicated to the word width at the top level to form an all-zeros reset word.
  localparam logic DFF_RESET_BIT = 1'b0;

endpackage : d_flipflop_en_pkg

// File: rtl/d_flipflop_en_stage.sv
// One WIDTH-bit register with synchronous reset and load enable.
module d_ff_stage #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : d_ff_stage

// File: rtl/d_flipflop_en.sv
// Enabled register chain: STAGES cascaded WIDTH-bit stages sharing one enable;
// with default parameters it is a plain 1-bit enabled D flip-flop.
module d_flipflop_en
  import d_flipflop_en_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int unsigned      STAGES    = DFF_DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DFF_RESET_BIT}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic             B,
  output logic [WIDTH-1:0] Q
);

  // Keeps the stage array legal while the guard below reports a bad STAGES.
  localparam int unsigned NSTG = (STAGES < 1) ? 1 : STAGES;

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("d_flipflop_en: STAGES must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [NSTG];

  generate
    for (genvar k = 0; k < NSTG; k++) begin : g_stage
      logic [WIDTH-1:0] stage_d;

      if (k == 0) begin : g_head
        assign stage_d = A;
      end else begin : g_link
        assign stage_d = stage_q[k-1];
      end

      d_ff_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk_i (clock),
        .rst_i (reset),
        .en_i  (B),
        .d_i   (stage_d),
        .q_o   (stage_q[k])
      );
    end
  endgenerate

  assign Q = stage_q[NSTG-1];

endmodule : d_flipflop_en

// File: tb/tb_d_flipflop_en.sv
// Directed bench: a default 1-bit flip-flop and an 8-bit, 3-stage delay line.
module tb_d_flipflop_en;

  logic       clock;
  logic       r1, a1, b1, q1;
  logic       r8, b8;
  logic [7:0] a8, q8;

  int n_checks = 0;
  int n_fail   = 0;

  d_flipflop_en u_ff (
    .clock (clock),
    .reset (r1),
    .A     (a1),
    .B     (b1),
    .Q     (q1)
  );

  d_flipflop_en #(
    .WIDTH     (8),
    .STAGES    (3),
    .RESET_VAL (8'hA5)
  ) u_dl (
    .clock (clock),
    .reset (r8),
    .A     (a8),
    .B     (b8),
    .Q     (q8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step1(input logic r, input logic a, input logic b,
                       input logic e, input string tag);
    r1 = r; a1 = a; b1 = b;
    @(posedge clock); #1;
    check(tag, {7'b0, q1}, {7'b0, e});
  endtask

  task automatic step8(input logic r, input logic [7:0] a, input logic b,
                       input logic [7:0] e, input string tag);
    r8 = r; a8 = a; b8 = b;
    @(posedge clock); #1;
    check(tag, q8, e);
  endtask

  initial begin
    r1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    r8 = 1'b0; a8 = 8'h00; b8 = 1'b0;

    // 1-bit flip-flop
    step1(1, 1, 1, 0, "ff_reset");
    step1(0, 0, 0, 0, "ff_hold_a0b0");
    step1(0, 1, 0, 0, "ff_hold_a1b0");
    step1(0, 0, 1, 0, "ff_load_a0");
    step1(0, 1, 1, 1, "ff_load_a1");
    step1(0, 0, 0, 1, "ff_hold1_1");
    step1(0, 0, 0, 1, "ff_hold1_2");
    step1(0, 0, 0, 1, "ff_hold1_3");
    step1(0, 0, 1, 0, "ff_reenable_0");
    step1(0, 1, 1, 1, "ff_load_again");
    // A moving between edges must not reach Q
    a1 = 1'b0; #2;
    check("ff_no_comb_path", {7'b0, q1}, 8'h01);
    step1(1, 1, 1, 0, "ff_reset_priority");
    step1(0, 1, 1, 1, "ff_after_reset");

    // 8-bit, 3-stage delay line
    step8(1, 8'hFF, 1, 8'hA5, "dl_reset");
    step8(0, 8'h01, 1, 8'hA5, "dl_fill_1");
    step8(0, 8'h02, 1, 8'hA5, "dl_fill_2");
    step8(0, 8'h03, 1, 8'h01, "dl_out_01");
    step8(0, 8'h44, 0, 8'h01, "dl_hold");
    step8(0, 8'h55, 0, 8'h01, "dl_hold_2");
    step8(0, 8'h04, 1, 8'h02, "dl_out_02");
    step8(0, 8'h05, 1, 8'h03, "dl_out_03");
    // restart with 01, 02 in flight, then reset mid-operation
    step8(1, 8'hEE, 0, 8'hA5, "dl_reset2");
    step8(0, 8'h01, 1, 8'hA5, "dl_inflight_1");
    step8(0, 8'h02, 1, 8'hA5, "dl_inflight_2");
    step8(1, 8'h03, 1, 8'hA5, "dl_midop_reset");
    step8(0, 8'h7F, 1, 8'hA5, "dl_refill_1");
    step8(0, 8'h7F, 1, 8'hA5, "dl_refill_2");
    step8(0, 8'h7F, 1, 8'h7F, "dl_refill_3");
    step8(0, 8'h80, 0, 8'h7F, "dl_final_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_d_flipflop_en
